// File: rtl/alu32_result_stage.sv
// Purpose : ALU output stage: selects the unit result by opcode, derives flags, and buffers
//           {result, flags} in a main + skid register pair with valid/ready handshakes.
// Latency : 1 cycle (an entry accepted at edge N is on Out in cycle N+1); 1 entry/cycle throughput.
// Backpressure: absorbs up to two entries while OutReady=0; InReady (registered) drops once both are full.
//
// Ports:
//   Clk, Rst_n                         clock, asynchronous active-low reset
//   InValid / InReady                  upstream handshake
//   Op                                 000 AND, 001 OR, 010 XOR, 011 ADD, 100 SUB, 101 NOR, 110 SLT, 111 illegal
//   AndRes, OrRes, XorRes              logic unit results
//   SumRes, SumCout, SumOvf            adder result, carry-out, signed overflow (SUB done by the adder)
//   OutValid / OutReady                downstream handshake
//   Out, Zero, Negative, Carry,
//   Overflow, OpErr                    buffered result and its flags
//   AcceptCnt                          wrapping count of accepted entries
module alu32_result_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              InValid,
  output logic              InReady,
  input  logic [2:0]        Op,
  input  logic [DATA_W-1:0] AndRes,
  input  logic [DATA_W-1:0] OrRes,
  input  logic [DATA_W-1:0] XorRes,
  input  logic [DATA_W-1:0] SumRes,
  input  logic              SumCout,
  input  logic              SumOvf,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [DATA_W-1:0] Out,
  output logic              Zero,
  output logic              Negative,
  output logic              Carry,
  output logic              Overflow,
  output logic              OpErr,
  output logic [CNT_W-1:0]  AcceptCnt
);

  // Entry layout: {result, zero, negative, carry, overflow, op_err}
  localparam int ENT_W = DATA_W + 5;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [ENT_W-1:0]   main_q, main_d;
  logic [ENT_W-1:0]   skid_q, skid_d;
  logic               in_ready_q, in_ready_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [DATA_W-1:0]  res;
  logic               is_sum;
  logic               op_err;
  logic [ENT_W-1:0]   new_entry;
  logic               accept;
  logic               drain;

  // Result select and flag derivation on the incoming operands.
  always_comb begin
    res    = '0;
    is_sum = 1'b0;
    op_err = 1'b0;
    case (Op)
      3'b000: res = AndRes;
      3'b001: res = OrRes;
      3'b010: res = XorRes;
      3'b011: begin res = SumRes; is_sum = 1'b1; end
      3'b100: begin res = SumRes; is_sum = 1'b1; end
      3'b101: res = ~OrRes;
      // Signed less-than: sign of (In1-In2) corrected by overflow.
      3'b110: res = {{(DATA_W-1){1'b0}}, SumRes[DATA_W-1] ^ SumOvf};
      default: op_err = 1'b1;
    endcase
    new_entry = {res, (res == '0), res[DATA_W-1], is_sum & SumCout, is_sum & SumOvf, op_err};
  end

  // in_ready_q mirrors (state != TWO); it is 0 in reset, so no accept can happen then.
  assign accept = InValid & in_ready_q;
  assign drain  = (state_q != ST_EMPTY) & OutReady;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    cnt_d   = cnt_q;
    if (accept) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          main_d  = new_entry;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        case ({accept, drain})
          2'b10: begin skid_d = new_entry; state_d = ST_TWO; end
          2'b01: state_d = ST_EMPTY;
          2'b11: main_d = new_entry;
          default: state_d = ST_ONE;
        endcase
      end
      ST_TWO: begin
        // Accept is impossible here (InReady=0), so only the drain matters.
        if (drain) begin
          main_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    in_ready_d = (state_d != ST_TWO);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= ST_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
      cnt_q      <= cnt_d;
    end
  end

  assign {Out, Zero, Negative, Carry, Overflow, OpErr} = main_q;
  assign OutValid  = (state_q != ST_EMPTY);
  assign InReady   = in_ready_q;
  assign AcceptCnt = cnt_q;

endmodule

// File: tb/tb_alu32_result_stage.sv
// Purpose : stimulus and reference checking for alu32_result_stage (main instance CNT_W=16,
//           second instance CNT_W=4 on the same inputs for counter wrap).
// Latency / backpressure: inputs driven 1 time unit after the rising edge, outputs sampled there too.
module tb_alu32_result_stage;

  localparam logic [2:0] OP_AND = 3'd0, OP_OR = 3'd1, OP_XOR = 3'd2, OP_ADD = 3'd3,
                         OP_SUB = 3'd4, OP_NOR = 3'd5, OP_SLT = 3'd6, OP_ILL = 3'd7;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        InValid = 1'b0;
  logic        OutReady = 1'b0;
  logic [2:0]  Op = 3'd0;
  logic [31:0] AndRes = '0, OrRes = '0, XorRes = '0, SumRes = '0;
  logic        SumCout = 1'b0, SumOvf = 1'b0;

  logic        InReady, OutValid, Zero, Negative, Carry, Overflow, OpErr;
  logic [31:0] Out;
  logic [15:0] AcceptCnt;
  logic        in_ready4, out_valid4, zero4, neg4, carry4, ovf4, operr4;
  logic [31:0] out4;
  logic [3:0]  cnt4;

  logic [36:0] obs, obs4;
  assign obs  = {Out, Zero, Negative, Carry, Overflow, OpErr};
  assign obs4 = {out4, zero4, neg4, carry4, ovf4, operr4};

  int n_checks = 0;
  int n_fail   = 0;

  alu32_result_stage #(.DATA_W(32), .CNT_W(16)) u_dut (
    .Clk(Clk), .Rst_n(Rst_n), .InValid(InValid), .InReady(InReady), .Op(Op),
    .AndRes(AndRes), .OrRes(OrRes), .XorRes(XorRes), .SumRes(SumRes),
    .SumCout(SumCout), .SumOvf(SumOvf), .OutValid(OutValid), .OutReady(OutReady),
    .Out(Out), .Zero(Zero), .Negative(Negative), .Carry(Carry), .Overflow(Overflow),
    .OpErr(OpErr), .AcceptCnt(AcceptCnt)
  );

  alu32_result_stage #(.DATA_W(32), .CNT_W(4)) u_dut4 (
    .Clk(Clk), .Rst_n(Rst_n), .InValid(InValid), .InReady(in_ready4), .Op(Op),
    .AndRes(AndRes), .OrRes(OrRes), .XorRes(XorRes), .SumRes(SumRes),
    .SumCout(SumCout), .SumOvf(SumOvf), .OutValid(out_valid4), .OutReady(OutReady),
    .Out(out4), .Zero(zero4), .Negative(neg4), .Carry(carry4), .Overflow(ovf4),
    .OpErr(operr4), .AcceptCnt(cnt4)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  // Upstream adder model: produces the sum/difference with carry-out and signed overflow.
  function automatic logic [33:0] adder(input logic [31:0] a, input logic [31:0] b, input bit sub);
    logic [32:0] s;
    longint      si;
    logic        v;
    if (sub) begin
      s  = {1'b0, a} + {1'b0, ~b} + 33'd1;
      si = longint'($signed(a)) - longint'($signed(b));
    end else begin
      s  = {1'b0, a} + {1'b0, b};
      si = longint'($signed(a)) + longint'($signed(b));
    end
    v = (si > 64'sd2147483647) || (si < -64'sd2147483648);
    return {v, s};
  endfunction

  // Reference: expected {result, zero, negative, carry, overflow, op_err} from the operands.
  function automatic logic [36:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        c, v, e;
    longint      sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    c = 1'b0; v = 1'b0; e = 1'b0; r = '0;
    case (op)
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_ADD: begin
        r = a + b;
        c = (longint'(a) + longint'(b)) > 64'sd4294967295;
        v = (sa + sb) != longint'($signed(r));
      end
      OP_SUB: begin
        r = a - b;
        c = (a >= b);
        v = (sa - sb) != longint'($signed(r));
      end
      OP_NOR: r = ~(a | b);
      OP_SLT: r = (sa < sb) ? 32'd1 : 32'd0;
      default: e = 1'b1;
    endcase
    return {r, (r == 32'd0), r[31], c, v, e};
  endfunction

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [33:0] ad;
    ad = adder(a, b, (op == OP_SUB) || (op == OP_SLT));
    Op      = op;
    AndRes  = a & b;
    OrRes   = a | b;
    XorRes  = a ^ b;
    SumRes  = ad[31:0];
    SumCout = ad[32];
    SumOvf  = ad[33];
  endtask

  task automatic do_reset;
    Rst_n = 1'b0;
    InValid = 1'b0;
    OutReady = 1'b0;
    repeat (2) @(posedge Clk);
    #1 Rst_n = 1'b1;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset;
    Rst_n = 1'b0;
    InValid = 1'b1;
    OutReady = 1'b0;
    drive(OP_ADD, 32'd1, 32'd2);
    repeat (3) @(posedge Clk);
    #1;
    n_checks++;
    if ({OutValid, InReady, out_valid4, in_ready4} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_handshake: got %b, expected 0000", {OutValid, InReady, out_valid4, in_ready4});
    end
    n_checks++;
    if (obs !== 37'd0) begin
      n_fail++;
      $display("FAIL reset_out_flags: got %h, expected 0", obs);
    end
    n_checks++;
    if ({AcceptCnt, cnt4} !== 20'd0) begin
      n_fail++;
      $display("FAIL reset_count: got %h/%h, expected 0/0", AcceptCnt, cnt4);
    end
    Rst_n = 1'b1;
    #1;
    n_checks++;
    if (InReady !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready_before_edge: got %b, expected 0", InReady);
    end
    @(posedge Clk);
    #1;
    n_checks++;
    if ({InReady, OutValid} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_ready_after_edge: got %b, expected 10", {InReady, OutValid});
    end
    InValid = 1'b0;
  endtask

  task automatic test_op_sweep;
    logic [2:0]  ops [10];
    logic [31:0] as_ [10];
    logic [31:0] bs [10];
    logic [31:0] eo [10];
    logic [4:0]  ef [10];
    ops = '{OP_OR, OP_NOR, OP_ADD, OP_SLT, OP_ILL, OP_AND, OP_XOR, OP_SUB, OP_ADD, OP_SUB};
    as_ = '{32'hF0F0_0000, 32'hF0F0_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h1234_5678,
            32'hFFFF_0000, 32'hFF00_FF00, 32'd5, 32'h7FFF_FFFF, 32'd7};
    bs  = '{32'h0, 32'h0, 32'h1, 32'h0, 32'h9, 32'h0000_FFFF, 32'h0F0F_0F0F, 32'd7, 32'h1, 32'd5};
    eo  = '{32'hF0F0_0000, 32'h0F0F_FFFF, 32'h0, 32'h1, 32'h0, 32'h0, 32'hF00F_F00F,
            32'hFFFF_FFFE, 32'h8000_0000, 32'h2};
    ef  = '{5'b01000, 5'b00000, 5'b10100, 5'b00000, 5'b10001, 5'b10000, 5'b01000,
            5'b01000, 5'b01010, 5'b00100};
    do_reset();
    OutReady = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(ops[i], as_[i], bs[i]);
      InValid = 1'b1;
      @(posedge Clk);
      #1;
      n_checks++;
      if ({OutValid, obs} !== {1'b1, eo[i], ef[i]}) begin
        n_fail++;
        $display("FAIL op_sweep[%0d]: got valid=%b out=%h flags=%b, expected valid=1 out=%h flags=%b",
                 i, OutValid, Out, obs[4:0], eo[i], ef[i]);
      end
    end
    InValid = 1'b0;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_back_to_back;
    logic [31:0] a [3];
    logic [31:0] b [3];
    logic [2:0]  op [3];
    logic [36:0] e [3];
    for (int i = 0; i < 3; i++) begin
      op[i] = 3'($urandom_range(0, 6));
      a[i]  = $urandom;
      b[i]  = $urandom;
      e[i]  = model(op[i], a[i], b[i]);
    end
    do_reset();
    OutReady = 1'b0;
    drive(op[0], a[0], b[0]);
    InValid = 1'b1;
    @(posedge Clk);
    #1;
    n_checks++;
    if ({OutValid, InReady, obs} !== {2'b11, e[0]}) begin
      n_fail++;
      $display("FAIL bp_first: got v=%b r=%b %h, expected v=1 r=1 %h", OutValid, InReady, obs, e[0]);
    end
    drive(op[1], a[1], b[1]);
    @(posedge Clk);
    #1;
    n_checks++;
    if ({OutValid, InReady, obs, AcceptCnt} !== {2'b10, e[0], 16'd2}) begin
      n_fail++;
      $display("FAIL bp_full: got v=%b r=%b %h cnt=%0d, expected v=1 r=0 %h cnt=2",
               OutValid, InReady, obs, AcceptCnt, e[0]);
    end
    drive(op[2], a[2], b[2]);
    @(posedge Clk);
    #1;
    n_checks++;
    if ({OutValid, InReady, obs, AcceptCnt} !== {2'b10, e[0], 16'd2}) begin
      n_fail++;
      $display("FAIL bp_hold: got v=%b r=%b %h cnt=%0d, expected v=1 r=0 %h cnt=2",
               OutValid, InReady, obs, AcceptCnt, e[0]);
    end
    OutReady = 1'b1;
    @(posedge Clk);
    #1;
    n_checks++;
    if ({OutValid, InReady, obs} !== {2'b11, e[1]}) begin
      n_fail++;
      $display("FAIL bp_second_out: got v=%b r=%b %h, expected v=1 r=1 %h", OutValid, InReady, obs, e[1]);
    end
    @(posedge Clk);
    #1;
    n_checks++;
    if ({OutValid, obs} !== {1'b1, e[2]}) begin
      n_fail++;
      $display("FAIL bp_third_out: got v=%b %h, expected v=1 %h", OutValid, obs, e[2]);
    end
    InValid = 1'b0;
    @(posedge Clk);
    #1;
    n_checks++;
    if ({OutValid, AcceptCnt} !== {1'b0, 16'd3}) begin
      n_fail++;
      $display("FAIL bp_drained: got v=%b cnt=%0d, expected v=0 cnt=3", OutValid, AcceptCnt);
    end
  endtask

  task automatic test_streaming;
    logic [36:0] q [$];
    logic [36:0] exp_e;
    logic [31:0] a, b;
    logic [2:0]  op;
    int acc = 0;
    int cyc = 0;
    do_reset();
    a = '0; b = '0; op = '0;
    while ((acc < 100 || q.size() != 0) && cyc < 5000) begin
      if (acc < 100) begin
        InValid = ($urandom_range(0, 3) != 0);
        op = 3'($urandom_range(0, 7));
        a  = $urandom;
        b  = ($urandom_range(0, 7) == 0) ? a : $urandom;
        drive(op, a, b);
      end else begin
        InValid = 1'b0;
      end
      OutReady = (acc >= 100) ? 1'b1 : ($urandom_range(0, 2) != 0);
      @(negedge Clk);
      if (OutValid && OutReady) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL stream_extra: got unexpected output %h, expected none", obs);
        end else begin
          exp_e = q.pop_front();
          if (obs !== exp_e) begin
            n_fail++;
            $display("FAIL stream_data: got %h, expected %h", obs, exp_e);
          end
        end
      end
      if (InValid && InReady) begin
        q.push_back(model(op, a, b));
        acc++;
      end
      @(posedge Clk);
      #1;
      cyc++;
    end
    InValid = 1'b0;
    n_checks++;
    if (cyc >= 5000) begin
      n_fail++;
      $display("FAIL stream_timeout: got %0d accepts and %0d pending, expected 100 and 0", acc, q.size());
    end
    n_checks++;
    if ({AcceptCnt, cnt4, OutValid} !== {16'd100, 4'd4, 1'b0}) begin
      n_fail++;
      $display("FAIL stream_count: got cnt=%0d cnt4=%0d v=%b, expected 100 4 0", AcceptCnt, cnt4, OutValid);
    end
  endtask

  task automatic test_wrap;
    logic [31:0] a, b;
    logic [2:0]  op;
    logic [36:0] e;
    do_reset();
    OutReady = 1'b1;
    InValid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      e  = model(op, a, b);
      drive(op, a, b);
      @(posedge Clk);
      #1;
      n_checks++;
      if ({out_valid4, in_ready4, obs4} !== {2'b11, e}) begin
        n_fail++;
        $display("FAIL wrap_data[%0d]: got v=%b r=%b %h, expected v=1 r=1 %h", i, out_valid4, in_ready4, obs4, e);
      end
    end
    InValid = 1'b0;
    n_checks++;
    if ({cnt4, AcceptCnt} !== {4'd1, 16'd17}) begin
      n_fail++;
      $display("FAIL wrap_count: got cnt4=%0d cnt=%0d, expected 1 17", cnt4, AcceptCnt);
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic test_mid_reset;
    logic [36:0] ex;
    do_reset();
    OutReady = 1'b0;
    InValid = 1'b1;
    drive(OP_XOR, $urandom, $urandom);
    @(posedge Clk);
    #1;
    drive(OP_SUB, $urandom, $urandom);
    @(posedge Clk);
    #1;
    n_checks++;
    if ({OutValid, InReady} !== 2'b10) begin
      n_fail++;
      $display("FAIL midrst_full: got v=%b r=%b, expected v=1 r=0", OutValid, InReady);
    end
    #2 Rst_n = 1'b0;
    #1;
    n_checks++;
    if ({OutValid, InReady, obs, AcceptCnt} !== {2'b00, 37'd0, 16'd0}) begin
      n_fail++;
      $display("FAIL midrst_async: got v=%b r=%b %h cnt=%0d, expected all 0", OutValid, InReady, obs, AcceptCnt);
    end
    ex = model(OP_OR, 32'h0000_00A5, 32'h0300_0000);
    drive(OP_OR, 32'h0000_00A5, 32'h0300_0000);
    OutReady = 1'b1;
    @(posedge Clk);
    #1 Rst_n = 1'b1;
    @(posedge Clk);
    #1;
    n_checks++;
    if ({InReady, OutValid} !== 2'b10) begin
      n_fail++;
      $display("FAIL midrst_release: got r=%b v=%b, expected r=1 v=0", InReady, OutValid);
    end
    @(posedge Clk);
    #1;
    n_checks++;
    if ({OutValid, obs, AcceptCnt} !== {1'b1, ex, 16'd1}) begin
      n_fail++;
      $display("FAIL midrst_first_out: got v=%b %h cnt=%0d, expected v=1 %h cnt=1", OutValid, obs, AcceptCnt, ex);
    end
    InValid = 1'b0;
    @(posedge Clk);
    #1;
    n_checks++;
    if (OutValid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_no_dup: got v=%b, expected 0", OutValid);
    end
  endtask

  initial begin
    test_reset();
    test_op_sweep();
    test_back_to_back();
    test_streaming();
    test_wrap();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
